// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path (and the future transmitter).
//   - platform defaults for clock frequency and line rate
//   - 8N1 frame constant (number of data bits)
//   - receiver state encoding (3 bits)
package uart_rx_fifo_pkg;

  localparam int DEF_CLK_FREQ    = 40_000_000;
  localparam int DEF_BAUD        = 9600;
  localparam int FRAME_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO, 2^DEPTH_LOG2 entries of WIDTH bits.
// Ports:
//   clk, rst    clock, synchronous active-low reset (empties the FIFO)
//   push_i      write wdata_i this cycle
//   wdata_i     write data
//   pop_i       advance the head (ignored while empty)
//   rdata_o     head entry, zero while empty
//   empty_o     no entries
//   full_o      all entries occupied
//   drop_o      push_i was refused because the FIFO was full with no pop
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit separates full (MSBs differ) from empty (equal).
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                   (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;

  assign wptr_d  = wptr_q + PW'(do_push);
  assign rptr_d  = rptr_q + PW'(do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver feeding a show-ahead byte FIFO.
// Ports:
//   clk         CPU clock
//   rst         synchronous active-low reset
//   rxd         asynchronous serial line, idles high
//   rd_en       pop request (ignored while data_valid=0)
//   rd_data     head byte, 8'h00 when empty
//   data_valid  FIFO non-empty
//   fifo_full   FIFO holds 2^DEPTH_LOG2 bytes
//   overrun     sticky: a received byte was dropped on a full FIFO
//   frame_err   sticky: a stop bit was sampled low
//   clr_err     clears both sticky flags (a same-cycle set wins)
// Internal state_q holds the receiver state for observation.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       data_valid,
  output logic       fifo_full,
  output logic       overrun,
  output logic       frame_err,
  input  logic       clr_err
);

  localparam int            DIV       = CLK_FREQ / BAUD;
  localparam int            TW        = $clog2(DIV);
  localparam logic [TW-1:0] HALF_LOAD = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(DIV - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(FRAME_DATA_BITS - 1);

  logic                       rx_meta_q, rxs_q, rxs_prev_q;
  rx_state_e                  state_q;
  logic [TW-1:0]              tcnt_q;
  logic [2:0]                 bcnt_q;
  logic [FRAME_DATA_BITS-1:0] shift_q;
  logic                       overrun_q, frame_err_q;
  logic                       tick, fall, stop_ok, stop_bad;
  logic                       fifo_empty, fifo_drop;

  // Synchroniser and edge history reset to the idle line level so that
  // release from reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rxd;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign tick     = (tcnt_q == '0);
  assign fall     = rxs_prev_q & ~rxs_q;
  assign stop_ok  = (state_q == RX_STOP) && tick && rxs_q;
  assign stop_bad = (state_q == RX_STOP) && tick && !rxs_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RX_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (fall) begin
            tcnt_q  <= HALF_LOAD;
            state_q <= RX_START;
          end
        end
        RX_START: begin
          if (!tick) begin
            tcnt_q <= tcnt_q - TW'(1);
          end else if (!rxs_q) begin
            tcnt_q  <= FULL_LOAD;
            bcnt_q  <= '0;
            state_q <= RX_DATA;
          end else begin
            // Line went back high before mid-start: glitch, not a frame.
            state_q <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (!tick) begin
            tcnt_q <= tcnt_q - TW'(1);
          end else begin
            shift_q <= {rxs_q, shift_q[FRAME_DATA_BITS-1:1]};
            tcnt_q  <= FULL_LOAD;
            if (bcnt_q == LAST_BIT) begin
              state_q <= RX_STOP;
            end else begin
              bcnt_q <= bcnt_q + 3'd1;
            end
          end
        end
        RX_STOP: begin
          if (!tick) begin
            tcnt_q <= tcnt_q - TW'(1);
          end else begin
            state_q <= rxs_q ? RX_IDLE : RX_WAIT_IDLE;
          end
        end
        RX_WAIT_IDLE: begin
          // A held-low line (break) must not start another frame.
          if (rxs_q) begin
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (fifo_drop)    overrun_q <= 1'b1;
      else if (clr_err) overrun_q <= 1'b0;
      if (stop_bad)     frame_err_q <= 1'b1;
      else if (clr_err) frame_err_q <= 1'b0;
    end
  end

  // The byte is pushed on the same edge that samples a good stop bit.
  sync_fifo #(
    .WIDTH      (FRAME_DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (stop_ok),
    .wdata_i (shift_q),
    .pop_i   (rd_en),
    .rdata_o (rd_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .drop_o  (fifo_drop)
  );

  assign data_valid = ~fifo_empty;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule
